// File: rtl/nvram_uploader.sv
// Shadow NVRAM window served to the HPS over the ioctl upload channel.
// Define NVRAM_CHECKSUM_EN to append a negated byte-sum at address 2^ADDR_W.
module nvram_uploader #(
  parameter int          ADDR_W   = 8,
  parameter logic [15:0] WIN_BASE = 16'h1E00,
  parameter logic [7:0]  INDEX    = 8'd4
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_we,
  input  logic        ioctl_upload,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_rd,
  input  logic [24:0] ioctl_addr,
  output logic [7:0]  ioctl_din,
  output logic        ioctl_wait,
  output logic        busy,
  output logic        dirty,
  output logic        overflow
);

  localparam int          DEPTH   = 1 << ADDR_W;
  localparam logic [24:0] DEPTH_A = 25'(DEPTH);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] UPLOAD = 3'd2;
  localparam logic [2:0] READ1  = 3'd3;
  localparam logic [2:0] READ2  = 3'd4;
  localparam logic [2:0] DRAIN  = 3'd5;
`ifdef NVRAM_CHECKSUM_EN
  localparam logic [2:0]      SUM       = 3'd1;
  localparam logic [ADDR_W:0] SUM_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] SUM_LAST  = (ADDR_W+1)'(DEPTH + 1);

  function automatic logic [7:0] negate8(input logic [7:0] v);
    return 8'(~v + 8'd1);
  endfunction

  logic [ADDR_W:0] sum_cnt;
  logic            vld_p0;
  logic [7:0]      acc;
  logic [7:0]      csum;
`endif

  logic [2:0]        state;
  logic              upload_q;
  logic [15:0]       diff;
  logic              hit;
  logic [ADDR_W-1:0] off;
  logic              session_start;
  logic              rd_accept;

  logic [ADDR_W-1:0] fifo_off [4];
  logic [7:0]        fifo_dat [4];
  logic [1:0]        wr_ptr;
  logic [1:0]        rd_ptr;
  logic [2:0]        cnt;
  logic              push;
  logic              pop;
  logic              drop;

  logic [7:0]        mem [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [7:0]        mem_wdata;
  logic [ADDR_W-1:0] raddr;
  logic [7:0]        rdata_p0;
  logic [24:0]       addr_q;
  logic [7:0]        rd_byte;

  assign diff          = cpu_addr - WIN_BASE;
  assign hit           = cpu_we && ((diff >> ADDR_W) == 16'd0);
  assign off           = diff[ADDR_W-1:0];
  assign session_start = ioctl_upload && !upload_q && (ioctl_index == INDEX);
  assign rd_accept     = (state == UPLOAD) && ioctl_upload && ioctl_rd;
  assign busy          = (state != IDLE);

  // Outside IDLE the buffer read port belongs to the upload, so hits queue up.
  assign push = hit && (state != IDLE) && (cnt != 3'd4);
  assign drop = hit && (state != IDLE) && (cnt == 3'd4);
  assign pop  = (state == DRAIN) && (cnt != 3'd0);

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = off;
    mem_wdata = cpu_dout;
    if (state == IDLE && hit) begin
      mem_we = 1'b1;
    end else if (pop) begin
      mem_we    = 1'b1;
      mem_waddr = fifo_off[rd_ptr];
      mem_wdata = fifo_dat[rd_ptr];
    end
  end

`ifdef NVRAM_CHECKSUM_EN
  assign raddr = (state == SUM) ? sum_cnt[ADDR_W-1:0] : addr_q[ADDR_W-1:0];
`else
  assign raddr = addr_q[ADDR_W-1:0];
`endif

  always_comb begin
    rd_byte = 8'hFF;
    if (addr_q < DEPTH_A) rd_byte = rdata_p0;
`ifdef NVRAM_CHECKSUM_EN
    else if (addr_q == DEPTH_A) rd_byte = csum;
`endif
  end

  // Stage p0: registered buffer read shared by reads and the checksum scan
  always_ff @(posedge clk_sys) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    rdata_p0 <= mem[raddr];
    if (push) begin
      fifo_off[wr_ptr] <= off;
      fifo_dat[wr_ptr] <= cpu_dout;
    end
    if (rd_accept) addr_q <= ioctl_addr;
`ifdef NVRAM_CHECKSUM_EN
    if (state == IDLE && session_start) acc <= 8'd0;
    if (state == SUM) begin
      if (vld_p0) acc <= acc + rdata_p0;
      if (sum_cnt == SUM_LAST) csum <= negate8(acc);
    end
`endif
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state      <= IDLE;
      upload_q   <= 1'b0;
      wr_ptr     <= 2'd0;
      rd_ptr     <= 2'd0;
      cnt        <= 3'd0;
      dirty      <= 1'b0;
      overflow   <= 1'b0;
      ioctl_din  <= 8'h00;
      ioctl_wait <= 1'b0;
`ifdef NVRAM_CHECKSUM_EN
      sum_cnt    <= '0;
      vld_p0     <= 1'b0;
`endif
    end else begin
      upload_q <= ioctl_upload;
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      cnt <= cnt + {2'b00, push} - {2'b00, pop};
      if (drop)   overflow <= 1'b1;
      if (mem_we) dirty    <= 1'b1;
      case (state)
        IDLE: begin
          if (session_start) begin
            dirty <= 1'b0;
`ifdef NVRAM_CHECKSUM_EN
            state      <= SUM;
            ioctl_wait <= 1'b1;
            sum_cnt    <= '0;
            vld_p0     <= 1'b0;
`else
            state <= UPLOAD;
`endif
          end
        end
`ifdef NVRAM_CHECKSUM_EN
        // Stage p1: accumulate the byte fetched one cycle earlier
        SUM: begin
          sum_cnt <= sum_cnt + 1'b1;
          vld_p0  <= (sum_cnt < SUM_DEPTH);
          if (sum_cnt == SUM_LAST) begin
            state      <= UPLOAD;
            ioctl_wait <= 1'b0;
          end
        end
`endif
        UPLOAD: begin
          if (!ioctl_upload) begin
            state <= DRAIN;
          end else if (ioctl_rd) begin
            state      <= READ1;
            ioctl_wait <= 1'b1;
          end
        end
        READ1: state <= READ2;
        READ2: begin
          ioctl_din  <= rd_byte;
          ioctl_wait <= 1'b0;
          state      <= ioctl_upload ? UPLOAD : DRAIN;
        end
        DRAIN: begin
          if (cnt == 3'd0 && !push) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nvram_uploader.sv
// Directed bench for nvram_uploader; expected read bytes go through a queue.
module tb_nvram_uploader;

`ifdef NVRAM_CHECKSUM_EN
  localparam int ENTRY_WAIT = 258;
`else
  localparam int ENTRY_WAIT = 0;
`endif

  logic        clk_sys = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_dout = 8'h00;
  logic        cpu_we = 1'b0;
  logic        ioctl_upload = 1'b0;
  logic [7:0]  ioctl_index = 8'h00;
  logic        ioctl_rd = 1'b0;
  logic [24:0] ioctl_addr = 25'd0;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic        busy;
  logic        dirty;
  logic        overflow;

  int passed = 0;
  int total = 0;
  logic [7:0] exp_q[$];
  int n_empty;
  int n_full;
  int n_tmp;

  nvram_uploader #(.ADDR_W(8), .WIN_BASE(16'h1E00), .INDEX(8'd4)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n),
    .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_we(cpu_we),
    .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index),
    .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr),
    .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait),
    .busy(busy), .dirty(dirty), .overflow(overflow)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, want);
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    cpu_addr = a;
    cpu_dout = d;
    cpu_we   = 1'b1;
    tick();
    cpu_we   = 1'b0;
  endtask

  task automatic start_session(input logic [7:0] idx, input int exp_wait, input logic with_rd);
    int n;
    ioctl_index  = idx;
    ioctl_upload = 1'b1;
    ioctl_addr   = 25'd0;
    ioctl_rd     = with_rd;
    tick();
    ioctl_rd = 1'b0;
    n = 0;
    while (ioctl_wait === 1'b1 && n < 400) begin
      n++;
      tick();
    end
    check($sformatf("entry_wait_idx%0d", idx), n, exp_wait);
  endtask

  task automatic end_session(output int n);
    ioctl_upload = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 50) begin
      n++;
      tick();
    end
    check("back_to_idle", busy, 1'b0);
  endtask

  task automatic do_read(input logic [24:0] a, input logic [7:0] want);
    int n;
    exp_q.push_back(want);
    ioctl_addr = a;
    ioctl_rd   = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    n = 0;
    while (ioctl_wait === 1'b1 && n < 20) begin
      n++;
      tick();
    end
    check($sformatf("rd_wait_%0d", a), n, 2);
    check($sformatf("rd_data_%0d", a), ioctl_din, exp_q.pop_front());
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_din", ioctl_din, 8'h00);
    check("rst_wait", ioctl_wait, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_dirty", dirty, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    rst_n = 1'b1;
    tick();

    // Direct IDLE writes, then a basic session
    cpu_write(16'h1E00, 8'h11);
    cpu_write(16'h1EFF, 8'h22);
    cpu_write(16'h1E10, 8'h5A);
    check("dirty_after_write", dirty, 1'b1);
    start_session(8'd4, ENTRY_WAIT, 1'b0);
    check("busy_in_session", busy, 1'b1);
    check("dirty_cleared_entry", dirty, 1'b0);
    do_read(25'd16, 8'h5A);
    end_session(n_empty);
    check("dirty_after_empty_drain", dirty, 1'b0);

    // Writes just outside the window
    cpu_write(16'h1DFF, 8'h77);
    cpu_write(16'h1F00, 8'h88);
    check("dirty_outside_window", dirty, 1'b0);
    start_session(8'd4, ENTRY_WAIT, 1'b0);
    do_read(25'd0, 8'h11);
    do_read(25'd255, 8'h22);
    do_read(25'd300, 8'hFF);
`ifndef NVRAM_CHECKSUM_EN
    do_read(25'd256, 8'hFF);
`endif

    // FIFO fill and overflow during a session
    for (int i = 1; i <= 4; i++) cpu_write(16'h1E00, 8'(i));
    check("no_overflow_at_4", overflow, 1'b0);
    cpu_write(16'h1E00, 8'd5);
    check("overflow_at_5", overflow, 1'b1);
    check("dirty_during_session", dirty, 1'b0);
    end_session(n_full);
    check("drain_pop_cycles", n_full - n_empty, 4);
    check("dirty_after_drain", dirty, 1'b1);
    check("overflow_sticky", overflow, 1'b1);

    // Read coinciding with session start is ignored
    start_session(8'd4, ENTRY_WAIT, 1'b1);
    do_read(25'd0, 8'h04);
    end_session(n_tmp);

    // Foreign index session is ignored
    start_session(8'd0, 0, 1'b0);
    check("busy_foreign", busy, 1'b0);
    ioctl_addr = 25'd0;
    ioctl_rd   = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    check("no_wait_foreign_0", ioctl_wait, 1'b0);
    tick();
    check("no_wait_foreign_1", ioctl_wait, 1'b0);
    cpu_write(16'h1E05, 8'h66);
    check("dirty_foreign_write", dirty, 1'b1);
    ioctl_upload = 1'b0;
    tick();
    start_session(8'd4, ENTRY_WAIT, 1'b0);
    do_read(25'd5, 8'h66);

    // Session ends while the read is in READ1
    exp_q.push_back(8'h22);
    ioctl_addr = 25'd255;
    ioctl_rd   = 1'b1;
    tick();
    ioctl_rd     = 1'b0;
    ioctl_upload = 1'b0;
    check("drop_wait_t1", ioctl_wait, 1'b1);
    tick();
    check("drop_wait_t2", ioctl_wait, 1'b1);
    tick();
    check("drop_wait_t3", ioctl_wait, 1'b0);
    check("drop_data_t3", ioctl_din, exp_q.pop_front());
    check("drop_in_drain", busy, 1'b1);
    tick();
    check("drop_to_idle", busy, 1'b0);

`ifdef NVRAM_CHECKSUM_EN
    for (int i = 0; i < 256; i++) cpu_write(16'h1E00 + 16'(i), 8'h01);
    start_session(8'd4, ENTRY_WAIT, 1'b0);
    do_read(25'd256, 8'h00);
    end_session(n_tmp);
    cpu_write(16'h1E00, 8'h03);
    start_session(8'd4, ENTRY_WAIT, 1'b0);
    do_read(25'd256, 8'hFE);
    end_session(n_tmp);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
